seq_divider: RTL

//   Multicycle signed 32-bit restoring divider in the ALU/multdiv complex.

---
 rtl/multdiv_pkg.sv | 15 +
 rtl/div_step.sv | 30 +++
 rtl/seq_divider.sv | 125 ++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide complex.
// Divider width default, FSM state encoding and counter width.
package multdiv_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int COUNT_W   = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SIGN,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left,
// trial-subtract the divisor magnitude, restore on borrow.
module div_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             diff_unused;

  assign sh     = {rem, quo[WIDTH-1]};
  assign diff   = {1'b0, sh} - {2'b00, dvs};
  assign borrow = diff[WIDTH+1];

  // A non-borrowing difference is below the divisor, so bit WIDTH is zero.
  assign diff_unused = diff[WIDTH];

  assign rem_nxt = borrow ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider, WIDTH+2 cycle fixed latency.
// Define DIV_REMAINDER_EN to add the signed data_remainder output.
module seq_divider
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q;
  div_state_t       state_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [CW-1:0]    cnt_q;
  logic             sign_q_q;
  logic             dz_q;
  logic             start;
`ifdef DIV_REMAINDER_EN
  logic             sign_r_q;
`endif

  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // busy stays high through the RDY cycle, blocking a start there.
  assign start = ctrl_div && (state_q == IDLE) && !busy;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .dvs    (dvs_q),
    .rem_nxt(rem_n),
    .quo_nxt(quo_n)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cnt_q == CW'(WIDTH-1)) state_d = SIGN;
      SIGN: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      cnt_q          <= '0;
      sign_q_q       <= 1'b0;
      dz_q           <= 1'b0;
      busy           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_r_q       <= 1'b0;
      data_remainder <= '0;
`endif
    end else begin
      data_resultRDY <= (state_q == DONE);
      data_exception <= (state_q == DONE) && dz_q;
      if (start)               busy <= 1'b1;
      else if (data_resultRDY) busy <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rem_q    <= '0;
            quo_q    <= abs_a;
            dvs_q    <= abs_b;
            cnt_q    <= '0;
            sign_q_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_q     <= (data_operandB == '0);
`ifdef DIV_REMAINDER_EN
            sign_r_q <= data_operandA[WIDTH-1];
`endif
          end
        end
        RUN: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q + 1'b1;
        end
        SIGN: begin
          data_result <= dz_q ? '0 : (sign_q_q ? -quo_q : quo_q);
`ifdef DIV_REMAINDER_EN
          // With a zero divisor every trial succeeds, leaving |A| in rem.
          data_remainder <= sign_r_q ? -rem_q : rem_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
